uart_rx_word64: RTL and testbench

- UART receiver with 64-bit word assembly; the receive end of the link driven by the team's 64-bit UART transmit path.
- Samples `uart_rxd` (8N1, LSB first) and collects 8 consecutive bytes into one 64-bit word.
- Presents the word with a one-cycle completion pulse and flags framing errors.
- Instantiated on the receive side of the system top, alongside the transmit block, sharing `clk`/`rst_n`.

---
 rtl/uart_rx_word64.sv | 159 +++++++++++++++
 tb/tb_uart_rx_word64.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word64.sv
// 8N1 UART receiver that assembles eight consecutive bytes (first byte in [7:0])
// into a 64-bit word, with a one-cycle completion pulse and a framing-error pulse.
module uart_rx_word64 #(
    parameter int CLK_F        = 50_000_000,
    parameter int UART_BPS     = 115200,
    parameter int CLK_GOAL     = CLK_F / UART_BPS,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rxd,
    output logic [63:0] data_64,
    output logic        data_out_done,
    output logic        frame_err
);

    localparam int CNT_W    = $clog2(CLK_GOAL);
    localparam int TO_LIMIT = TIMEOUT_BITS * CLK_GOAL;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_GOAL / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_GOAL - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_s;
    logic             rx_prev;
    logic             rx_fall;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [2:0]       byte_idx;
    logic [7:0]       shift_reg;
    logic [55:0]      word_buf;
    logic [TO_W-1:0]  to_cnt;

    assign rx_fall = rx_prev & ~rx_s;

    // Two-flop synchroniser plus one delayed copy for edge detection; idle line is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            byte_idx      <= '0;
            shift_reg     <= '0;
            word_buf      <= '0;
            to_cnt        <= '0;
            data_64       <= '0;
            data_out_done <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            data_out_done <= 1'b0;
            frame_err     <= 1'b0;

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (rx_fall) begin
                        to_cnt <= '0;
                        state  <= START;
                    end else if (byte_idx == 3'd0) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        // Line idle too long: abandon the partial word without an error.
                        to_cnt   <= '0;
                        byte_idx <= 3'd0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= 3'd0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt           <= '0;
                        shift_reg[bit_cnt] <= rx_s;
                        bit_cnt            <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            // Returning at mid stop bit leaves half a bit to catch the next start edge.
                            state <= IDLE;
                            if (byte_idx == 3'd7) begin
                                data_64       <= {shift_reg, word_buf};
                                data_out_done <= 1'b1;
                                byte_idx      <= 3'd0;
                            end else begin
                                for (int i = 0; i < 7; i++) begin
                                    if (byte_idx == 3'(i)) begin
                                        word_buf[i*8 +: 8] <= shift_reg;
                                    end
                                end
                                byte_idx <= byte_idx + 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            byte_idx  <= 3'd0;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    baud_cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    baud_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_word64.sv
// Directed bench for uart_rx_word64: a driver serialises 8N1 frames, a monitor
// pops expected words from a queue on every completion pulse.
module tb_uart_rx_word64;

    localparam int CLK_F = 2_000_000;
    localparam int BPS   = 100_000;
    localparam int G     = CLK_F / BPS;
    localparam int LAT   = 2 + G / 2 + 9 * G + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rxd = 1'b1;
    logic [63:0] data_64;
    logic        data_out_done;
    logic        frame_err;

    logic [63:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int done_seen = 0, done_exp = 0;
    int ferr_seen = 0, ferr_exp = 0;
    int overlap_viol = 0, pulse_viol = 0, hold_viol = 0;
    int cyc = 0;
    int last_start_cyc = 0, last_done_cyc = 0;
    logic        prev_done = 1'b0;
    logic [63:0] prev_data = '0;

    uart_rx_word64 #(
        .CLK_F(CLK_F),
        .UART_BPS(BPS),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_rxd(uart_rxd),
        .data_64(data_64),
        .data_out_done(data_out_done),
        .frame_err(frame_err)
    );

    // Clock and cycle counter
    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_out_done && frame_err) overlap_viol++;
            if (data_out_done && prev_done) pulse_viol++;
            if (!data_out_done && data_64 !== prev_data) hold_viol++;
            if (frame_err) ferr_seen++;
            if (data_out_done) begin
                done_seen++;
                last_done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got %h expected no completion", data_64);
                end else begin
                    check("word", data_64, exp_q.pop_front());
                end
            end
        end
        prev_done = data_out_done;
        prev_data = data_64;
    end

    // Driver tasks
    task automatic bit_time(input logic v);
        uart_rxd = v;
        repeat (G) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) bit_time(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        uart_rxd = 1'b1;
    endtask

    task automatic send_word(input logic [63:0] w);
        exp_q.push_back(w);
        done_exp++;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) last_start_cyc = cyc;
            send_byte(w[i*8 +: 8], 1'b1);
        end
    endtask

    task automatic settle(input string name);
        for (int i = 0; i < 4 * G && exp_q.size() != 0; i++) @(negedge clk);
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        check({name, "_done_count"}, 64'(done_seen), 64'(done_exp));
        check({name, "_ferr_count"}, 64'(ferr_seen), 64'(ferr_exp));
    endtask

    initial begin
        int lat;
        rst_n    = 1'b0;
        uart_rxd = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data", data_64, 64'd0);
        check("rst_done", 64'(data_out_done), 64'd0);
        check("rst_ferr", 64'(frame_err), 64'd0);
        rst_n = 1'b1;
        idle_bits(2);

        // Basic word plus completion latency
        send_word(64'h0807060504030201);
        idle_bits(1);
        settle("s1");
        lat = last_done_cyc - last_start_cyc;
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d +/-1", lat, LAT);
        end

        // Two words with zero idle gap
        send_word(64'h1817161514131211);
        send_word(64'hA7A6A5A4A3A2A1A0);
        idle_bits(1);
        settle("s2");

        // Framing error on byte 4 discards the partial word
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h34, 1'b0);
        ferr_exp++;
        idle_bits(2);
        send_word(64'h5555555555555555);
        idle_bits(1);
        settle("s3");

        // Idle timeout drops three bytes
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h43, 1'b1);
        idle_bits(25);
        send_word(64'hC3C3C3C3C3C3C3C3);
        idle_bits(1);
        settle("s4");

        // Short low glitch is rejected as a false start
        uart_rxd = 1'b0;
        repeat (6) @(negedge clk);
        uart_rxd = 1'b1;
        idle_bits(2);
        send_word(64'h0F1E2D3C4B5A6978);
        idle_bits(1);
        settle("s5");

        // Reset in the middle of byte 5
        send_byte(8'h61, 1'b1);
        send_byte(8'h62, 1'b1);
        send_byte(8'h63, 1'b1);
        send_byte(8'h64, 1'b1);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_data", data_64, 64'd0);
        check("midrst_done", 64'(data_out_done), 64'd0);
        check("midrst_ferr", 64'(frame_err), 64'd0);
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        rst_n    = 1'b1;
        idle_bits(2);
        send_word(64'hDEADBEEF01234567);
        idle_bits(1);
        settle("s6");

        check("done_ferr_overlap", 64'(overlap_viol), 64'd0);
        check("done_pulse_width", 64'(pulse_viol), 64'd0);
        check("data_hold", 64'(hold_viol), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
